// File: rtl/in_handshake_pkg.sv
// Shared constants for the IN-instruction input handshake: default widths
// and the FSM state encoding that is also exposed on the debug LEDs.
package in_handshake_pkg;

    localparam int LARGURA_DEF      = 18;
    localparam int LARGURA_CONT_DEF = 8;
    localparam int DADOS_W          = 32;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESPERA_SOLTO  = 2'd1,
        ESPERA_APERTO = 2'd2,
        ESPERA_LIBERA = 2'd3
    } estado_t;

    // The key is active-low: a synchronized 0 means the user is pressing it.
    function automatic logic tecla_apertada(input logic nivel_sinc);
        return ~nivel_sinc;
    endfunction

endpackage

// File: rtl/in_handshake_sincronizador.sv
// Two-flop synchronizer for an asynchronous level input (board keys).
// Reset loads RESET_VAL so an active-low key reads "released" after reset.
module sincronizador #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift of the asynchronous level into the clock domain.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/in_handshake.sv
// Input handshake for the IN instruction: stalls the CPU, waits for a fresh
// press of the confirm key, captures the switches and pulses valido.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// OCIOSO        | idle, waiting for pedido
// ESPERA_SOLTO  | request seen, waiting for the key to read released
// ESPERA_APERTO | key released, first press captures the switches
// ESPERA_LIBERA | capture done, waiting for the key release before idling
module in_handshake
    import in_handshake_pkg::*;
#(
    parameter int LARGURA      = LARGURA_DEF,
    parameter int LARGURA_CONT = LARGURA_CONT_DEF
) (
    input  logic                    clock,
    input  logic                    reseta,
    input  logic                    pedido,
    input  logic                    botao,
    input  logic [LARGURA-1:0]      switch,
    output logic                    halt,
    output logic [DADOS_W-1:0]      dados,
    output logic                    valido,
    output logic [LARGURA_CONT-1:0] contagem,
    output logic [1:0]              estado
);

    logic                    botao_sinc;
    logic                    apertado;

    estado_t                 estado_q;
    logic                    halt_q;
    logic                    valido_q;
    logic [DADOS_W-1:0]      dados_q;
    logic [DADOS_W-1:0]      dados_d;
    logic [LARGURA_CONT-1:0] contagem_q;
    logic [LARGURA_CONT-1:0] contagem_d;

    sincronizador #(
        .RESET_VAL (1'b1)
    ) u_sinc_botao (
        .clock_i (clock),
        .reset_i (reseta),
        .async_i (botao),
        .sync_o  (botao_sinc)
    );

    assign apertado = tecla_apertada(botao_sinc);

    // Zero-extended switch value and the incremented count for a capture.
    always_comb begin
        dados_d                = '0;
        dados_d[LARGURA-1:0]   = switch;
        contagem_d             = contagem_q + LARGURA_CONT'(1);
    end

    // Handshake FSM with registered halt/valido and capture registers.
    always_ff @(posedge clock) begin
        if (reseta) begin
            estado_q   <= OCIOSO;
            halt_q     <= 1'b0;
            valido_q   <= 1'b0;
            dados_q    <= '0;
            contagem_q <= '0;
        end else begin
            valido_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (pedido) begin
                        estado_q <= ESPERA_SOLTO;
                        halt_q   <= 1'b1;
                    end
                end
                // A key held across the request must be released first.
                ESPERA_SOLTO: begin
                    if (!apertado) begin
                        estado_q <= ESPERA_APERTO;
                    end
                end
                ESPERA_APERTO: begin
                    if (apertado) begin
                        estado_q   <= ESPERA_LIBERA;
                        halt_q     <= 1'b0;
                        valido_q   <= 1'b1;
                        dados_q    <= dados_d;
                        contagem_q <= contagem_d;
                    end
                end
                ESPERA_LIBERA: begin
                    if (!apertado) begin
                        estado_q <= OCIOSO;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                    halt_q   <= 1'b0;
                end
            endcase
        end
    end

    assign halt     = halt_q;
    assign valido   = valido_q;
    assign dados    = dados_q;
    assign contagem = contagem_q;
    assign estado   = estado_q;

endmodule

// File: tb/tb_in_handshake.sv
// Directed bench for in_handshake: reset, basic capture and latency, held
// key, ignored request, reset mid-handshake and counter wrap.
module tb_in_handshake;

    logic        clock;
    logic        reseta;
    logic        pedido;
    logic        botao;
    logic [17:0] switch;
    logic        halt;
    logic [31:0] dados;
    logic        valido;
    logic [7:0]  contagem;
    logic [1:0]  estado;

    int n_assert = 0;
    int n_fail   = 0;

    in_handshake dut (
        .clock    (clock),
        .reseta   (reseta),
        .pedido   (pedido),
        .botao    (botao),
        .switch   (switch),
        .halt     (halt),
        .dados    (dados),
        .valido   (valido),
        .contagem (contagem),
        .estado   (estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [17:0] sw;
        logic [17:0] sw_last;

        reseta = 1'b1;
        pedido = 1'b0;
        botao  = 1'b1;
        switch = '0;
        sw_last = '0;

        // Reset then idle
        tick(2);
        reseta = 1'b0;
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_valido", 32'(valido), 32'd0);
        chk("rst_dados", dados, 32'd0);
        chk("rst_contagem", 32'(contagem), 32'd0);
        chk("rst_estado", 32'(estado), 32'd0);

        // Basic capture
        switch = 18'h3FFFF;
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        chk("cap_estado_solto", 32'(estado), 32'd1);
        chk("cap_halt_on", 32'(halt), 32'd1);
        tick();
        chk("cap_estado_aperto", 32'(estado), 32'd2);
        tick(8);
        botao  = 1'b0;
        switch = 18'h2A5F3;
        tick();
        chk("cap_lat1_valido", 32'(valido), 32'd0);
        tick();
        chk("cap_lat2_valido", 32'(valido), 32'd0);
        chk("cap_lat2_halt", 32'(halt), 32'd1);
        tick();
        chk("cap_valido", 32'(valido), 32'd1);
        chk("cap_halt_off", 32'(halt), 32'd0);
        chk("cap_dados", dados, 32'h0002A5F3);
        chk("cap_contagem", 32'(contagem), 32'd1);
        chk("cap_estado_libera", 32'(estado), 32'd3);
        switch = 18'h01111;
        tick();
        chk("cap_valido_pulse", 32'(valido), 32'd0);
        chk("cap_dados_hold", dados, 32'h0002A5F3);
        botao = 1'b1;
        tick(2);
        chk("cap_estado_still_libera", 32'(estado), 32'd3);
        tick();
        chk("cap_estado_idle", 32'(estado), 32'd0);

        // Held key: pressed before the request
        botao = 1'b0;
        tick(3);
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        chk("held_estado", 32'(estado), 32'd1);
        tick(5);
        chk("held_estado_stuck", 32'(estado), 32'd1);
        chk("held_halt", 32'(halt), 32'd1);
        chk("held_contagem", 32'(contagem), 32'd1);
        chk("held_dados", dados, 32'h0002A5F3);
        botao = 1'b1;
        tick(3);
        chk("held_estado_aperto", 32'(estado), 32'd2);
        botao  = 1'b0;
        switch = 18'h00123;
        tick(3);
        chk("held_valido", 32'(valido), 32'd1);
        chk("held_dados_new", dados, 32'h00000123);
        chk("held_contagem2", 32'(contagem), 32'd2);

        // Ignored request in ESPERA_LIBERA
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        chk("ign_estado", 32'(estado), 32'd3);
        chk("ign_halt", 32'(halt), 32'd0);
        botao = 1'b1;
        tick(3);
        chk("ign_estado_idle", 32'(estado), 32'd0);
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        chk("ign_fresh_estado", 32'(estado), 32'd1);
        tick();
        chk("ign_fresh_aperto", 32'(estado), 32'd2);

        // Reset mid-handshake, with a press and a request in the same cycle
        botao  = 1'b0;
        pedido = 1'b1;
        reseta = 1'b1;
        tick();
        chk("mid_estado", 32'(estado), 32'd0);
        chk("mid_halt", 32'(halt), 32'd0);
        chk("mid_valido", 32'(valido), 32'd0);
        chk("mid_contagem", 32'(contagem), 32'd0);
        chk("mid_dados", dados, 32'd0);
        tick(2);
        chk("mid_hold_valido", 32'(valido), 32'd0);
        reseta = 1'b0;
        pedido = 1'b0;
        botao  = 1'b1;
        tick(4);
        chk("mid_after_estado", 32'(estado), 32'd0);
        chk("mid_after_valido", 32'(valido), 32'd0);
        chk("mid_after_contagem", 32'(contagem), 32'd0);

        // Wrap: 256 captures
        for (int i = 0; i < 256; i++) begin
            pedido = 1'b1;
            tick();
            pedido = 1'b0;
            tick();
            sw      = 18'(i * 257) ^ 18'h15555;
            sw_last = sw;
            switch  = sw;
            botao   = 1'b0;
            tick(3);
            chk("wrap_valido", 32'(valido), 32'd1);
            chk("wrap_contagem", 32'(contagem), 32'((i + 1) % 256));
            switch = ~sw;
            botao  = 1'b1;
            tick(3);
        end
        chk("wrap_final_contagem", 32'(contagem), 32'd0);
        chk("wrap_final_dados", dados, {14'd0, sw_last});
        chk("wrap_final_estado", 32'(estado), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
